// File: rtl/mpa_state_monitor_pkg.sv
// Shared definitions for the MPA control FSM and its monitor:
// state codes, number of defined codes and the legal-step table.
package mpa_pkg;

    localparam int NUM_ST = 11;

    localparam logic [3:0] S_Y0 = 4'd0;
    localparam logic [3:0] S_Y1 = 4'd1;
    localparam logic [3:0] S_Y2 = 4'd2;
    localparam logic [3:0] S_Y3 = 4'd3;
    localparam logic [3:0] S_Y4 = 4'd4;
    localparam logic [3:0] S_Y5 = 4'd5;
    localparam logic [3:0] S_Y6 = 4'd6;
    localparam logic [3:0] S_Y7 = 4'd7;
    localparam logic [3:0] S_Y8 = 4'd8;
    localparam logic [3:0] S_Y9 = 4'd9;
    localparam logic [3:0] S_YK = 4'd10;

    // True when the FSM may step from prev to cur. A step to Y0 is always
    // legal because the FSM reset is asynchronous and can strike anywhere.
    function automatic logic is_legal(input logic [3:0] prev, input logic [3:0] cur);
        logic ok;
        ok = 1'b0;
        if (cur == S_Y0) begin
            ok = 1'b1;
        end else begin
            case (prev)
                S_Y0:    ok = (cur == S_Y1);
                S_Y1:    ok = (cur == S_Y2);
                S_Y2:    ok = (cur == S_Y3);
                S_Y3:    ok = (cur == S_Y3) || (cur == S_Y4);
                S_Y4:    ok = (cur == S_Y5);
                S_Y5:    ok = (cur == S_Y6) || (cur == S_Y8);
                S_Y6:    ok = (cur == S_Y7);
                S_Y7:    ok = (cur == S_YK);
                S_Y8:    ok = (cur == S_YK);
                default: ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

endpackage

// File: rtl/mpa_state_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_cnt;

    // Count register: reset, clear, or step toward saturation.
    always_ff @(posedge clk) begin
        // NOTE: the reset is synchronous, so it lives inside the clocked branch
        // rather than in the sensitivity list.
        if (!reset) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != CNT_MAX)) begin
            // NOTE: clocked state always uses <= so every register sees the
            // pre-edge value of every other register.
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign q = r_cnt;

endmodule

// File: rtl/mpa_state_monitor.sv
// Monitor for the MPA control FSM state code: registered one-hot decode,
// transition legality check, run-length and Y3 wait measurement, sticky flags.
module mpa_state_monitor
    import mpa_pkg::S_Y0;
    import mpa_pkg::S_Y1;
    import mpa_pkg::S_Y3;
    import mpa_pkg::S_Y9;
    import mpa_pkg::S_YK;
    import mpa_pkg::is_legal;
#(
    parameter int CODE_W  = 4,
    parameter int NUM_ST  = mpa_pkg::NUM_ST,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CODE_W-1:0] state_code,
    input  logic              ack,
    output logic [NUM_ST-1:0] y_onehot,
    output logic              done,
    output logic [CNT_W-1:0]  last_run,
    output logic              wait_timeout,
    output logic              illegal
);

    logic [CODE_W-1:0] r_prev_code;
    logic              r_prev_vld;
    logic [NUM_ST-1:0] r_y_onehot;
    logic              r_done;
    logic [CNT_W-1:0]  r_last_run;
    logic              r_wait_timeout;
    logic              r_illegal;

    logic              w_in_range;
    logic              w_is_run;
    logic              w_is_wait;
    logic              w_is_yk;
    logic              w_done_set;
    logic              w_illegal_set;
    logic              w_wait_hit;
    logic [NUM_ST-1:0] w_y_dec;
    logic [CNT_W-1:0]  w_run_cnt;
    logic [CNT_W-1:0]  w_wait_cnt;

    assign w_in_range = (state_code < CODE_W'(NUM_ST));
    assign w_is_run   = (state_code >= S_Y1) && (state_code <= S_Y9);
    assign w_is_wait  = (state_code == S_Y3);
    assign w_is_yk    = (state_code == S_YK);

    // Done fires only on entry to Yk, never while Yk is held.
    assign w_done_set = w_is_yk && (!r_prev_vld || (r_prev_code != S_YK));

    // The first sample after reset has no predecessor, so only the range check applies.
    assign w_illegal_set = !w_in_range || (r_prev_vld && !is_legal(r_prev_code, state_code));

    // Fires only on the step from TIMEOUT-1 to TIMEOUT, so a long hold in Y3
    // (including saturation) cannot re-arm the flag after an ack.
    assign w_wait_hit = w_is_wait && (w_wait_cnt == CNT_W'(TIMEOUT - 1));

    // Combinational one-hot decode; out-of-range codes decode to all zeros.
    always_comb begin
        // NOTE: the default assignment first means every path drives w_y_dec,
        // so no latch is inferred.
        w_y_dec = '0;
        if (w_in_range) begin
            w_y_dec[state_code] = 1'b1;
        end
    end

    // Run length: cleared in Y0, counts Y1..Y9, holds in Yk and on bad codes.
    sat_counter #(.CNT_W(CNT_W)) u_run_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (state_code == S_Y0),
        .inc   (w_is_run),
        .q     (w_run_cnt)
    );

    // Consecutive samples spent in Y3.
    sat_counter #(.CNT_W(CNT_W)) u_wait_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (!w_is_wait),
        .inc   (w_is_wait),
        .q     (w_wait_cnt)
    );

    // Output registers, predecessor tracking and sticky flags (set beats ack).
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_prev_code    <= '0;
            r_prev_vld     <= 1'b0;
            r_y_onehot     <= '0;
            r_done         <= 1'b0;
            r_last_run     <= '0;
            r_wait_timeout <= 1'b0;
            r_illegal      <= 1'b0;
        end else begin
            r_prev_code <= state_code;
            r_prev_vld  <= 1'b1;
            r_y_onehot  <= w_y_dec;
            r_done      <= w_done_set;

            if (w_done_set) begin
                r_last_run <= w_run_cnt;
            end

            if (w_illegal_set) begin
                r_illegal <= 1'b1;
            end else if (ack) begin
                r_illegal <= 1'b0;
            end

            if (w_wait_hit) begin
                r_wait_timeout <= 1'b1;
            end else if (ack) begin
                r_wait_timeout <= 1'b0;
            end
        end
    end

    assign y_onehot     = r_y_onehot;
    assign done         = r_done;
    assign last_run     = r_last_run;
    assign wait_timeout = r_wait_timeout;
    assign illegal      = r_illegal;

endmodule

// File: tb/tb_mpa_state_monitor.sv
// Bench for mpa_state_monitor: a reference model pushes expected outputs to a
// scoreboard queue as each sample is driven; entries are popped and compared
// one cycle later when the DUT has registered that sample.
module tb_mpa_state_monitor;

    localparam int NUM_ST  = 11;
    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 16;
    localparam int CNT_MAX = 255;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [3:0]        state_code = 4'd0;
    logic              ack = 1'b0;
    logic [NUM_ST-1:0] y_onehot;
    logic              done;
    logic [CNT_W-1:0]  last_run;
    logic              wait_timeout;
    logic              illegal;

    always #5 clk = ~clk;

    mpa_state_monitor #(
        .CODE_W  (4),
        .NUM_ST  (NUM_ST),
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .state_code   (state_code),
        .ack          (ack),
        .y_onehot     (y_onehot),
        .done         (done),
        .last_run     (last_run),
        .wait_timeout (wait_timeout),
        .illegal      (illegal)
    );

    typedef struct packed {
        logic [NUM_ST-1:0] y;
        logic              dn;
        logic [CNT_W-1:0]  last;
        logic              to;
        logic              ill;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   step  = 0;

    // Reference model state.
    int m_prev     = 0;
    bit m_prev_vld = 0;
    int m_run      = 0;
    int m_wait     = 0;
    int m_last     = 0;
    bit m_ill      = 0;
    bit m_to       = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Legal step table written as prev*16+cur keys; any step to 0 is legal.
    function automatic bit legal_step(input int p, input int c);
        if (c == 0) return 1'b1;
        return (p * 16 + c) inside {1, 18, 35, 51, 52, 69, 86, 88, 103, 122, 138};
    endfunction

    // Advance the model by one clock edge and return the outputs it predicts.
    function automatic exp_t model_step(input int c, input bit a, input bit r);
        exp_t e;
        bit   in_rng;
        bit   ill_set;
        bit   to_set;
        bit   dn;
        e = '0;
        if (!r) begin
            m_prev = 0; m_prev_vld = 0; m_run = 0; m_wait = 0;
            m_last = 0; m_ill = 0; m_to = 0;
            return e;
        end
        in_rng  = (c < NUM_ST);
        ill_set = !in_rng || (m_prev_vld && !legal_step(m_prev, c));
        dn      = (c == 10) && (!m_prev_vld || m_prev != 10);
        if (dn) m_last = m_run;
        if (c == 0) m_run = 0;
        else if (c >= 1 && c <= 9 && m_run < CNT_MAX) m_run = m_run + 1;
        to_set = 1'b0;
        if (c == 3) begin
            if (m_wait < CNT_MAX) begin
                m_wait = m_wait + 1;
                to_set = (m_wait == TIMEOUT);
            end
        end else begin
            m_wait = 0;
        end
        m_ill = ill_set || (m_ill && !a);
        m_to  = to_set  || (m_to && !a);
        e.y    = in_rng ? (NUM_ST'(1) << c) : '0;
        e.dn   = dn;
        e.last = CNT_W'(m_last);
        e.to   = m_to;
        e.ill  = m_ill;
        m_prev = c;
        m_prev_vld = 1'b1;
        return e;
    endfunction

    // Drive one sample, let the DUT register it, then pop and compare.
    task automatic apply(input int c, input bit a, input bit r);
        exp_t e;
        string t;
        state_code = 4'(c);
        ack        = a;
        reset      = r;
        sb_q.push_back(model_step(c, a, r));
        @(posedge clk);
        #1;
        step++;
        e = sb_q.pop_front();
        t = $sformatf("s%0d c=%0d", step, c);
        check({t, " y_onehot"},     32'(y_onehot),     32'(e.y));
        check({t, " done"},         32'(done),         32'(e.dn));
        check({t, " last_run"},     32'(last_run),     32'(e.last));
        check({t, " wait_timeout"}, 32'(wait_timeout), 32'(e.to));
        check({t, " illegal"},      32'(illegal),      32'(e.ill));
    endtask

    task automatic run_seq(input int s[$]);
        foreach (s[i]) apply(s[i], 1'b0, 1'b1);
    endtask

    initial begin
        int s[$];

        // Reset state.
        apply(0, 0, 0);
        apply(0, 0, 0);
        check("rst y_onehot", 32'(y_onehot), 32'h0);
        check("rst last_run", 32'(last_run), 32'h0);

        // Path with x2=0.
        s = '{0, 1, 2, 3, 3, 4, 5, 6, 7, 10};
        run_seq(s);
        check("p1 done", 32'(done), 32'd1);
        check("p1 last_run", 32'(last_run), 32'd8);
        apply(0, 0, 1);
        check("p1 done gone", 32'(done), 32'd0);
        check("p1 illegal", 32'(illegal), 32'd0);

        // Path with x2=1.
        s = '{1, 2, 3, 4, 5, 8};
        run_seq(s);
        check("p2 y Y8", 32'(y_onehot), 32'h100);
        apply(10, 0, 1);
        check("p2 y Yk", 32'(y_onehot), 32'h400);
        check("p2 last_run", 32'(last_run), 32'd6);

        // Y3 wait: 15 samples stay quiet, the 16th raises the flag.
        s = '{0, 1, 2};
        run_seq(s);
        for (int i = 0; i < 15; i++) apply(3, 0, 1);
        check("wait 15", 32'(wait_timeout), 32'd0);
        apply(3, 0, 1);
        check("wait 16", 32'(wait_timeout), 32'd1);
        for (int i = 0; i < 3; i++) apply(3, 0, 1);
        apply(4, 0, 1);
        check("wait sticky", 32'(wait_timeout), 32'd1);
        apply(5, 1, 1);
        check("wait ack", 32'(wait_timeout), 32'd0);

        // Illegal steps, out-of-range code, ack versus set.
        s = '{0, 1, 2, 5};
        run_seq(s);
        check("ill 2->5", 32'(illegal), 32'd1);
        apply(0, 1, 1);
        check("ill ack", 32'(illegal), 32'd0);
        apply(12, 0, 1);
        check("ill code12", 32'(illegal), 32'd1);
        check("ill code12 y", 32'(y_onehot), 32'h0);
        apply(0, 1, 1);
        apply(1, 0, 1);
        apply(2, 0, 1);
        apply(5, 1, 1);
        check("ill set beats ack", 32'(illegal), 32'd1);
        apply(0, 1, 1);

        // Reset mid-run, then resume at code 4.
        s = '{1, 2, 3, 4, 5, 6};
        run_seq(s);
        apply(6, 0, 0);
        check("mid rst y", 32'(y_onehot), 32'h0);
        apply(4, 0, 1);
        check("post rst illegal", 32'(illegal), 32'd0);
        check("post rst last_run", 32'(last_run), 32'd0);
        s = '{5, 8, 10, 0};
        run_seq(s);

        // Asynchronous FSM reset 7->0 mid-run.
        s = '{1, 2, 3, 4, 5, 6, 7, 0};
        run_seq(s);
        check("7->0 done", 32'(done), 32'd0);
        check("7->0 illegal", 32'(illegal), 32'd0);
        s = '{1, 2, 3, 4, 5, 8, 10};
        run_seq(s);
        check("after 7->0 last_run", 32'(last_run), 32'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
